// File: rtl/fetch_seq16.sv
// fetch_seq16 -- fetch sequencer in front of the 16-bit program counter.
//
// Reads bytes from an 8-bit memory bus at the address held in the PC and
// assembles little-endian 16-bit words. It drives the PC's increment and load
// strobes and presents each assembled word on the transfer bus. It handles one
// command per transaction, accepted through a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   cmd_valid_i/ready_o  command handshake; cmd_op_i captured at accept
//                        (00 FETCH8, 01 FETCH16, 10 JUMP16, 11 reserved -> err)
//   pc_in_i              current PC value; mem_addr_o follows it combinationally
//   mem_req_o/ack_i      memory read request / data-valid on mem_data_i
//   pc_inc_o, pc_load_o  one-cycle PC strobes (never asserted together)
//   xfer_out_o           registered result word; xfer_valid_o marks a new one
//   err_o                one-cycle error strobe; busy_o = ~cmd_ready_o
//
// Optional build macro FETCH_TIMEOUT_EN: abort a memory request that has gone
// TIMEOUT_CYCLES request cycles without mem_ack_i (err pulse, no pc_inc).
// Without the macro the sequencer waits indefinitely for mem_ack_i.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// REQ_LO  | requesting low byte at PC; pc_inc on ack
// REQ_HI  | requesting high byte at PC (already advanced); pc_inc on ack
// LOAD    | JUMP16 only: pc_load with the assembled word
// DONE    | xfer_valid pulse
// FAIL    | err pulse (reserved op or memory timeout)

module fetch_seq16 #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned TO_W           = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [15:0] pc_in_i,
  output logic [15:0] mem_addr_o,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic        pc_inc_o,
  output logic        pc_load_o,
  output logic [15:0] xfer_out_o,
  output logic        xfer_valid_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam logic [1:0] OP_FETCH8  = 2'b00;
  localparam logic [1:0] OP_JUMP16  = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  // The timeout counter must be able to hold TIMEOUT_CYCLES-1.
  if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : g_to_w_check
    $error("fetch_seq16: TO_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_LO,
    S_REQ_HI,
    S_LOAD,
    S_DONE,
    S_FAIL
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] xfer_q, xfer_d;
  logic        to_expire;

`ifdef FETCH_TIMEOUT_EN
  // Down-counter loaded on entry to a request state; reaching zero on a
  // request cycle without ack means TIMEOUT_CYCLES cycles have been spent.
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_d == S_REQ_LO || state_d == S_REQ_HI) && state_d != state_q) begin
      to_cnt_d = TO_LOAD;
    end else if (mem_req_o && !mem_ack_i && to_cnt_q != '0) begin
      to_cnt_d = to_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign to_expire = (to_cnt_q == '0);
`else
  assign to_expire = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_FETCH8;
      lo_q    <= 8'h00;
      xfer_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      xfer_q  <= xfer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    lo_d         = lo_q;
    xfer_d       = xfer_q;
    cmd_ready_o  = 1'b0;
    mem_req_o    = 1'b0;
    pc_inc_o     = 1'b0;
    pc_load_o    = 1'b0;
    xfer_valid_o = 1'b0;
    err_o        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          state_d = (cmd_op_i == OP_RSVD) ? S_FAIL : S_REQ_LO;
        end
      end

      S_REQ_LO: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          pc_inc_o = 1'b1;
          lo_d     = mem_data_i;
          if (op_q == OP_FETCH8) begin
            xfer_d  = {8'h00, mem_data_i};
            state_d = S_DONE;
          end else begin
            state_d = S_REQ_HI;
          end
        end else if (to_expire) begin
          state_d = S_FAIL;
        end
      end

      S_REQ_HI: begin
        // pc_in_i has already advanced from the low-byte increment.
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          pc_inc_o = 1'b1;
          xfer_d   = {mem_data_i, lo_q};
          state_d  = (op_q == OP_JUMP16) ? S_LOAD : S_DONE;
        end else if (to_expire) begin
          state_d = S_FAIL;
        end
      end

      S_LOAD: begin
        pc_load_o = 1'b1;
        state_d   = S_DONE;
      end

      S_DONE: begin
        xfer_valid_o = 1'b1;
        state_d      = S_IDLE;
      end

      S_FAIL: begin
        // A partially fetched word is discarded; xfer_out keeps its old value.
        err_o   = 1'b1;
        lo_d    = 8'h00;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr_o = pc_in_i;
  assign xfer_out_o = xfer_q;
  assign busy_o     = ~cmd_ready_o;

endmodule

// File: tb/tb_fetch_seq16.sv
// tb_fetch_seq16 -- self-checking bench for fetch_seq16.
// The bench models the PC register and a 64 KiB byte memory. It predicts each
// command's result word, final PC, strobe counts and cycle timing from the
// command rules: little-endian word at the PC, +1 per byte, and JUMP16 loads
// the word.
module tb_fetch_seq16;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [15:0] pc_in_i;
  logic [15:0] mem_addr_o;
  logic        mem_req_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;
  logic        pc_inc_o;
  logic        pc_load_o;
  logic [15:0] xfer_out_o;
  logic        xfer_valid_o;
  logic        err_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  fetch_seq16 dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .pc_in_i(pc_in_i), .mem_addr_o(mem_addr_o),
    .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .pc_inc_o(pc_inc_o), .pc_load_o(pc_load_o),
    .xfer_out_o(xfer_out_o), .xfer_valid_o(xfer_valid_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  logic [7:0]  mem [0:65535];
  logic [15:0] pc_m;
  int checks = 0;
  int errors = 0;

  // Observations of the last command.
  int          r_valid_cyc, r_load_cyc, r_err_cyc, r_ready_cyc;
  int          r_inc, r_load, r_req, r_both, r_nack, r_hang;
  logic [15:0] r_word, r_addr0, r_addr1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and run it until the sequencer is idle again.
  // Cycle 1 is the cycle after the accept edge. wlo/whi are the wait cycles
  // before acking the low/high byte.
  task automatic run_cmd(input logic [1:0] op, input int wlo, input int whi);
    int   c, wait_cnt;
    logic inc_prev, load_prev;
    logic [15:0] xfer_prev;
    r_valid_cyc = -1; r_load_cyc = -1; r_err_cyc = -1; r_ready_cyc = -1;
    r_inc = 0; r_load = 0; r_req = 0; r_both = 0; r_nack = 0; r_hang = 1;
    r_word = 16'hxxxx; r_addr0 = 16'hxxxx; r_addr1 = 16'hxxxx;
    pc_in_i = pc_m; mem_ack_i = 1'b0;
    cmd_valid_i = 1'b1; cmd_op_i = op;
    @(posedge clk_i);
    c = 0; wait_cnt = 0; inc_prev = 1'b0; load_prev = 1'b0; xfer_prev = '0;
    while (c < 200) begin
      c++;
      #1;
      if (load_prev) pc_m = xfer_prev;
      else if (inc_prev) pc_m = pc_m + 16'd1;
      pc_in_i = pc_m;
      if (cmd_ready_o) begin
        cmd_valid_i = 1'b0;
      end else begin
        // cmd_valid while busy must be ignored.
        cmd_valid_i = 1'($urandom_range(0, 1));
        cmd_op_i    = 2'($urandom_range(0, 3));
      end
      #1;
      mem_ack_i  = 1'b0;
      mem_data_i = 8'($urandom);
      if (mem_req_o) begin
        if (wait_cnt == ((r_nack == 0) ? wlo : whi)) begin
          mem_ack_i  = 1'b1;
          mem_data_i = mem[mem_addr_o];
        end else begin
          wait_cnt++;
        end
      end
      #1;
      if (mem_ack_i && mem_req_o) begin
        if (r_nack == 0) r_addr0 = mem_addr_o;
        else r_addr1 = mem_addr_o;
        r_nack++;
        wait_cnt = 0;
      end
      if (mem_req_o) r_req++;
      if (pc_inc_o) r_inc++;
      if (pc_load_o) begin r_load++; r_load_cyc = c; end
      if (pc_inc_o && pc_load_o) r_both++;
      if (xfer_valid_o) begin r_valid_cyc = c; r_word = xfer_out_o; end
      if (err_o) r_err_cyc = c;
      inc_prev = pc_inc_o; load_prev = pc_load_o; xfer_prev = xfer_out_o;
      if (cmd_ready_o) begin
        r_ready_cyc = c;
        r_hang = 0;
        cmd_valid_i = 1'b0;
        mem_ack_i = 1'b0;
        break;
      end
      @(posedge clk_i);
    end
    chk("no_hang", 32'(r_hang), 32'd0);
  endtask

  task automatic do_cmd(input logic [1:0] op, input int wlo, input int whi);
    logic [15:0] p, p1, w, pe;
    int vc;
    p  = pc_m;
    p1 = p + 16'd1;
    w  = (op == 2'b00) ? {8'h00, mem[p]} : {mem[p1], mem[p]};
    if (op == 2'b10) pe = w;
    else pe = p + ((op == 2'b00) ? 16'd1 : 16'd2);
    vc = (op == 2'b00) ? 2 + wlo : ((op == 2'b01) ? 3 + wlo + whi : 4 + wlo + whi);
    run_cmd(op, wlo, whi);
    chk($sformatf("op%0d_word", op), 32'(r_word), 32'(w));
    chk($sformatf("op%0d_pc_end", op), 32'(pc_m), 32'(pe));
    chk($sformatf("op%0d_valid_cyc", op), 32'(r_valid_cyc), 32'(vc));
    chk($sformatf("op%0d_ready_cyc", op), 32'(r_ready_cyc), 32'(vc + 1));
    chk($sformatf("op%0d_n_inc", op), 32'(r_inc), (op == 2'b00) ? 32'd1 : 32'd2);
    chk($sformatf("op%0d_n_load", op), 32'(r_load), (op == 2'b10) ? 32'd1 : 32'd0);
    chk($sformatf("op%0d_n_req", op), 32'(r_req),
        32'((op == 2'b00) ? 1 + wlo : 2 + wlo + whi));
    chk($sformatf("op%0d_addr0", op), 32'(r_addr0), 32'(p));
    if (op != 2'b00) chk($sformatf("op%0d_addr1", op), 32'(r_addr1), 32'(p1));
    if (op == 2'b10) chk("jump_load_cyc", 32'(r_load_cyc), 32'(vc - 1));
    chk($sformatf("op%0d_inc_and_load", op), 32'(r_both), 32'd0);
    chk($sformatf("op%0d_no_err", op), 32'(r_err_cyc), 32'hFFFF_FFFF);
  endtask

  initial begin
    logic [15:0] p, xp;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 2'b00; pc_m = 16'h0000;
    pc_in_i = pc_m; mem_ack_i = 1'b0; mem_data_i = 8'h00;
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_strobes", 32'({pc_inc_o, pc_load_o, xfer_valid_o, err_o, busy_o}), 32'd0);
    chk("rst_xfer_out", 32'(xfer_out_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #2;

    // FETCH8 at 0x0100, zero wait.
    pc_m = 16'h0100; mem[16'h0100] = 8'hFE;
    do_cmd(2'b00, 0, 0);
    chk("f8_word_00fe", 32'(r_word), 32'h00FE);

    // FETCH16 at 0x0200 -> CAFE, PC ends at 0x0202.
    pc_m = 16'h0200; mem[16'h0200] = 8'hFE; mem[16'h0201] = 8'hCA;
    do_cmd(2'b01, 0, 0);
    chk("f16_word_cafe", 32'(r_word), 32'hCAFE);
    chk("f16_pc_0202", 32'(pc_m), 32'h0202);

    // JUMP16 with 2 wait cycles on each byte -> PC 0x1234.
    pc_m = 16'h0300; mem[16'h0300] = 8'h34; mem[16'h0301] = 8'h12;
    do_cmd(2'b10, 2, 2);
    chk("jump_pc_1234", 32'(pc_m), 32'h1234);

    // Reserved op: err only, nothing else moves.
    p = pc_m; xp = xfer_out_o;
    run_cmd(2'b11, 0, 0);
    chk("rsvd_err_cyc", 32'(r_err_cyc), 32'd1);
    chk("rsvd_ready_cyc", 32'(r_ready_cyc), 32'd2);
    chk("rsvd_quiet", 32'(r_req + r_inc + r_load), 32'd0);
    chk("rsvd_no_valid", 32'(r_valid_cyc), 32'hFFFF_FFFF);
    chk("rsvd_xfer_hold", 32'(xfer_out_o), 32'(xp));
    chk("rsvd_pc_hold", 32'(pc_m), 32'(p));

    // PC wrap through 0xFFFF.
    pc_m = 16'hFFFF;
    do_cmd(2'b01, 1, 0);

    // Reset while in REQ_HI, then a late ack.
    pc_m = 16'h0400; pc_in_i = pc_m; cmd_op_i = 2'b01; cmd_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = mem[16'h0400];
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0; pc_m = 16'h0401; pc_in_i = pc_m;
    #1;
    chk("mid_in_req_hi", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(cmd_ready_o), 32'd1);
    chk("mid_rst_req", 32'(mem_req_o), 32'd0);
    chk("mid_rst_xfer", 32'(xfer_out_o), 32'd0);
    mem_ack_i = 1'b1; mem_data_i = 8'h5A;
    #1;
    chk("mid_rst_ack_ignored", 32'({pc_inc_o, pc_load_o, xfer_valid_o, err_o, busy_o}), 32'd0);
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    @(posedge clk_i); #2;
    chk("post_rst_late_ack", 32'({mem_req_o, pc_inc_o, cmd_ready_o}), 32'b001);
    mem_ack_i = 1'b0;
    do_cmd(2'b00, 0, 0);

    // Randomized commands against the model.
    for (int n = 0; n < 40; n++) begin
      if ((n % 5) == 0) pc_m = 16'($urandom);
      do_cmd(2'($urandom_range(0, 2)), $urandom_range(0, 4), $urandom_range(0, 4));
    end

`ifdef FETCH_TIMEOUT_EN
    // No ack ever: 15 request cycles then err, nothing committed.
    p = pc_m; xp = xfer_out_o;
    run_cmd(2'b01, 1000, 0);
    chk("to_err_cyc", 32'(r_err_cyc), 32'd16);
    chk("to_req_cycles", 32'(r_req), 32'd15);
    chk("to_no_inc", 32'(r_inc + r_load), 32'd0);
    chk("to_no_valid", 32'(r_valid_cyc), 32'hFFFF_FFFF);
    chk("to_pc_hold", 32'(pc_m), 32'(p));
    chk("to_xfer_hold", 32'(xfer_out_o), 32'(xp));
    // Ack on the 15th request cycle completes normally.
    do_cmd(2'b01, 14, 0);
    do_cmd(2'b10, 3, 14);
`else
    // Without the timeout the sequencer simply waits.
    do_cmd(2'b01, 20, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
